// File: rtl/wash_pkg.sv
// Shared types and per-mode tables for the wash-cycle executor.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_PAUSE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] MODE_QUICK = 2'd0;
  localparam logic [1:0] MODE_STD   = 2'd1;
  localparam logic [1:0] MODE_HEAVY = 2'd2;
  localparam logic [1:0] MODE_SPIN  = 2'd3;

  // Base wash seconds; the weight in kg is added on top.
  function automatic logic [7:0] wash_base(input logic [1:0] m);
    case (m)
      MODE_QUICK: return 8'd10;
      MODE_STD:   return 8'd20;
      MODE_HEAVY: return 8'd30;
      default:    return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] rinse_time(input logic [1:0] m);
    case (m)
      MODE_QUICK: return 8'd5;
      MODE_STD:   return 8'd10;
      MODE_HEAVY: return 8'd15;
      default:    return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] spin_time(input logic [1:0] m);
    case (m)
      MODE_QUICK: return 8'd5;
      MODE_STD:   return 8'd5;
      MODE_HEAVY: return 8'd10;
      default:    return 8'd8;
    endcase
  endfunction

  // Price as 3-digit BCD.
  function automatic logic [11:0] price(input logic [1:0] m);
    case (m)
      MODE_QUICK: return 12'h005;
      MODE_STD:   return 12'h010;
      MODE_HEAVY: return 12'h015;
      default:    return 12'h003;
    endcase
  endfunction

endpackage

// File: rtl/bcd3_sub.sv
// Combinational 3-digit BCD subtractor: diff = a - b, borrow=1 when a < b.
module bcd3_sub (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] diff,
  output logic        borrow
);

  logic [4:0] w_t;
  logic       w_br;

  // Ripple the borrow from the ones digit upward, correcting negative digits by +10.
  always_comb begin
    w_t  = '0;
    w_br = 1'b0;
    diff = '0;
    for (int i = 0; i < 3; i++) begin
      w_t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, w_br};
      if (w_t[4]) begin
        diff[4*i +: 4] = w_t[3:0] + 4'd10;
        w_br           = 1'b1;
      end else begin
        diff[4*i +: 4] = w_t[3:0];
        w_br           = 1'b0;
      end
    end
    borrow = w_br;
  end

endmodule

// File: rtl/wash_run.sv
// Wash-cycle executor: charge the mode price, then run WASH -> RINSE -> SPIN
// with 1 s countdowns, honouring pause, lid interlock and abort.
// The inputs are plain pulses/levels with no handshake: start is honoured only
// in IDLE, pause_pos/abort_pos only while running or paused; otherwise dropped.
module wash_run
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  weight,
  input  logic [11:0] bal_in,
  input  logic        lid_open,
  input  logic        pause_pos,
  input  logic        abort_pos,
  output logic [2:0]  phase,
  output logic [7:0]  remain_s,
  output logic [11:0] bal_out,
  output logic        busy,
  output logic        paused,
  output logic        done,
  output logic        err,
  output logic [2:0]  dbg_state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t        r_state, w_state_nxt, r_ret;
  logic [1:0]    r_mode;
  logic [7:0]    r_weight;
  logic [11:0]   r_bal, r_bal_out;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_remain;
  logic          r_err;

  logic [7:0]    w_wbin;
  logic [11:0]   w_diff;
  logic          w_borrow;
  logic          w_tick, w_last, w_run, w_hold;
  state_t        w_first, w_next;

  // Phase that follows s; zero-length phases are skipped.
  function automatic state_t next_phase(input state_t s, input logic [1:0] m);
    case (s)
      ST_WASH:  return (rinse_time(m) != 8'd0) ? ST_RINSE : ST_SPIN;
      ST_RINSE: return ST_SPIN;
      ST_SPIN:  return ST_DONE;
      default:  return ST_IDLE;
    endcase
  endfunction

  // Countdown value loaded on entry to phase s.
  function automatic logic [7:0] time_of(input state_t s, input logic [1:0] m,
                                         input logic [7:0] wbin);
    case (s)
      ST_WASH:  return wash_base(m) + wbin;
      ST_RINSE: return rinse_time(m);
      ST_SPIN:  return spin_time(m);
      ST_DONE:  return 8'(DONE_TICKS);
      default:  return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] light(input state_t s);
    case (s)
      ST_WASH:  return 3'b001;
      ST_RINSE: return 3'b010;
      ST_SPIN:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  bcd3_sub u_sub (
    .a      (r_bal),
    .b      (price(r_mode)),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  assign w_wbin  = 8'(r_weight[7:4]) * 8'd10 + 8'(r_weight[3:0]);
  assign w_tick  = (r_presc == PRESC_MAX);
  assign w_last  = (r_remain == 8'd1);
  assign w_run   = (r_state == ST_WASH) || (r_state == ST_RINSE) || (r_state == ST_SPIN);
  assign w_hold  = lid_open || pause_pos;
  assign w_first = (r_mode == MODE_SPIN) ? ST_SPIN : ST_WASH;
  assign w_next  = next_phase(r_state, r_mode);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; priority abort > lid > pause > tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = w_borrow ? ST_IDLE : w_first;
      ST_WASH, ST_RINSE, ST_SPIN: begin
        if (abort_pos)            w_state_nxt = ST_IDLE;
        else if (w_hold)          w_state_nxt = ST_PAUSE;
        else if (w_tick && w_last) w_state_nxt = w_next;
      end
      ST_PAUSE: begin
        if (abort_pos)                   w_state_nxt = ST_IDLE;
        else if (pause_pos && !lid_open) w_state_nxt = r_ret;
      end
      ST_DONE:  if (w_tick && w_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: job latch, charge, prescaler and countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode    <= '0;
      r_weight  <= '0;
      r_bal     <= '0;
      r_bal_out <= '0;
      r_presc   <= '0;
      r_remain  <= '0;
      r_err     <= 1'b0;
      r_ret     <= ST_IDLE;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_mode   <= mode;
        r_weight <= weight;
        r_bal    <= bal_in;
        r_err    <= 1'b0;
      end else if (r_state == ST_CHECK) begin
        if (w_borrow) begin
          r_err     <= 1'b1;
          r_bal_out <= r_bal;
        end else begin
          r_bal_out <= w_diff;
          r_remain  <= time_of(w_first, r_mode, w_wbin);
          r_presc   <= '0;
        end
      end else if ((w_run || r_state == ST_PAUSE) && abort_pos) begin
        r_remain <= '0;
      end else if (w_run && w_hold) begin
        // Prescaler frozen on entry: a coincident tick does not count.
        r_ret <= r_state;
      end else if (w_run || r_state == ST_DONE) begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick)
          r_remain <= w_last ? time_of(w_next, r_mode, w_wbin) : r_remain - 8'd1;
      end
    end
  end

  // Decoded outputs; lights follow the frozen phase while paused.
  always_comb begin
    phase  = 3'b000;
    busy   = 1'b0;
    paused = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_CHECK: busy = 1'b1;
      ST_WASH, ST_RINSE, ST_SPIN: begin
        busy  = 1'b1;
        phase = light(r_state);
      end
      ST_PAUSE: begin
        busy   = 1'b1;
        paused = 1'b1;
        phase  = light(r_ret);
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign remain_s  = r_remain;
  assign bal_out   = r_bal_out;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
